herald_cmd_bridge: RTL and testbench
====================================

Name: herald_cmd_bridge

Overview:
- Parametrised host-to-accelerator command bridge for Herald compute cores (CORDIC and successors).
- Host issues byte-serial commands to set an opcode, load NUM_ARGS operands of ARG_W bits and start a job. The bridge then drives a valid/ready start handshake, waits for the core's done pulse, captures a RES_W-bit result and serves it back byte by byte.
- Generalises the fixed 2x32-bit operand / 32-bit readout pad protocol: parametrised widths and operand count, auto-incrementing pointers, error/status reporting and an optional watchdog.

Parameters:
- ARG_W, 32, operand width in bits; multiple of 8.
- NUM_ARGS, 2, number of operand registers; 1..16.
- RES_W, 64, result width in bits; multiple of 8.
- OP_W, 3, opcode width; 1..8.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- host_valid  in  1  command strobe; one command is accepted per cycle while high.
- host_cmd  in  3  command code.
- host_data  in  8  command data byte.
- rd_data  out  8  result byte at the read pointer (combinational from registers).
- status  out  8  {sel_idx[3:0], timeout, err, result_valid, busy}.
- core_opcode  out  OP_W  latched opcode.
- core_args  out  NUM_ARGS*ARG_W  operand registers; arg0 in the LSBs.
- core_start  out  1  start request; held until core_ready.
- core_ready  in  1  core accepts start.
- core_done  in  1  one-cycle result-valid pulse.
- core_result  in  RES_W  result, sampled when core_done is high.

Behaviour:
- Reset (async, immediate): state=IDLE; opcode, all args, result, sel_idx, wptr, rptr = 0; status = 0; core_start = 0; rd_data = 0.
- States:
  - IDLE: accepts commands.
  - ISSUE: core_start=1 until core_ready is sampled high, then -> WAIT.
  - WAIT: waits for core_done; on done captures core_result, sets result_valid, rptr=0, -> IDLE.
  - ISSUE and WAIT both report busy=1.
- Commands (acted on at the clock edge where host_valid=1; effects visible next cycle):
  - 0 NOP: no effect.
  - 1 SET_OP: opcode <= host_data[OP_W-1:0]; clears err.
  - 2 SEL_ARG: if host_data < NUM_ARGS, sel_idx <= host_data and wptr <= 0; otherwise err=1 and no other change.
  - 3 WR_BYTE: arg[sel_idx] byte[wptr] <= host_data. wptr increments and wraps from ARG_W/8-1 to 0.
  - 4 START: clears result_valid and timeout, -> ISSUE. core_start rises the following cycle.
  - 5 RD_PTR: if host_data < RES_W/8, rptr <= host_data; otherwise err=1.
  - 6 RD_BYTE: rptr increments and wraps from RES_W/8-1 to 0. The host samples rd_data before issuing RD_BYTE.
  - 7 ABORT: from any state -> IDLE. core_start drops next cycle, busy clears, args are kept, err cleared.
- While busy, every command except NOP and ABORT is ignored and sets err (sticky).
- core_done is sampled only in WAIT; a pulse in IDLE or ISSUE is ignored. Done in the same cycle as an accepted ABORT: ABORT wins, result is not captured.
- Reset mid-job returns to IDLE asynchronously; a later core_done is ignored.
- rd_data = result[8*rptr +: 8]. The result is held until the next core_done capture; START does not clear it, it only clears result_valid.
- Minimum latency: START accept -> core_start high 1 cycle; ready-to-done is core-defined; done -> result_valid high 1 cycle.

Optional Feature:
- Macro HERALD_BRIDGE_TIMEOUT_EN.
- When defined:
  - A counter runs in ISSUE and WAIT and resets on entering ISSUE.
  - On reaching TIMEOUT_CYC without done: -> IDLE, timeout=1, result_valid=0, core_start=0, result unchanged.
- When undefined: no counter; the bridge waits indefinitely and status bit3 is tied to 0.

Test Plan:
- Reset then read status -> 0x00, rd_data=0x00, core_start=0.
- SET_OP 0x03; SEL_ARG 0; WR_BYTE 0x78,0x56,0x34,0x12; SEL_ARG 1; WR_BYTE 0x04,0,0,0 -> core_opcode=3, core_args=0x00000004_12345678.
- START with core_ready low 5 cycles then high -> core_start high exactly 6 cycles. Done 10 cycles later with result 0x1122334455667788 -> status=0x12 (sel_idx=1, result_valid). Eight reads give rd_data 0x88,0x77,...,0x11, then wrap back to 0x88.
- SEL_ARG 5 with NUM_ARGS=2 -> err=1 and sel_idx unchanged; WR_BYTE while busy -> err=1 and arg unchanged; SET_OP -> err cleared.
- ABORT during WAIT, then core_done pulse -> busy=0, result_valid=0, result unchanged; rst_n low mid-ISSUE -> core_start falls without waiting for a clock edge.
- With HERALD_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16: START, ready high, done never asserted -> after 16 cycles status timeout=1, busy=0.

Source files
------------

// File: rtl/herald_cmd_bridge.sv
// Byte-serial host command bridge for Herald compute cores: operand load, start handshake, result readback.
// Optional watchdog enabled by defining HERALD_BRIDGE_TIMEOUT_EN.
module herald_cmd_bridge #(
    parameter int ARG_W       = 32,
    parameter int NUM_ARGS    = 2,
    parameter int RES_W       = 64,
    parameter int OP_W        = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_valid,
    input  logic [2:0]                host_cmd,
    input  logic [7:0]                host_data,
    output logic [7:0]                rd_data,
    output logic [7:0]                status,
    output logic [OP_W-1:0]           core_opcode,
    output logic [NUM_ARGS*ARG_W-1:0] core_args,
    output logic                      core_start,
    input  logic                      core_ready,
    input  logic                      core_done,
    input  logic [RES_W-1:0]          core_result
);

    localparam int ARG_BYTES = ARG_W / 8;
    localparam int RES_BYTES = RES_W / 8;
    localparam int AW_TOT    = NUM_ARGS * ARG_W;
    localparam int WPW       = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;
    localparam int RPW       = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_SET_OP  = 3'd1;
    localparam logic [2:0] CMD_SEL_ARG = 3'd2;
    localparam logic [2:0] CMD_WR_BYTE = 3'd3;
    localparam logic [2:0] CMD_START   = 3'd4;
    localparam logic [2:0] CMD_RD_PTR  = 3'd5;
    localparam logic [2:0] CMD_RD_BYTE = 3'd6;
    localparam logic [2:0] CMD_ABORT   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                busy;
    logic [OP_W-1:0]     opcode_q;
    logic [AW_TOT-1:0]   args_q;
    logic [RES_W-1:0]    result_q;
    logic [3:0]          sel_idx_q;
    logic [WPW-1:0]      wptr_q;
    logic [RPW-1:0]      rptr_q;
    logic                err_q;
    logic                result_valid_q;
    logic                timeout_flag;

    logic                abort_acc;
    logic                idle_cmd;
    logic                start_acc;
    logic                busy_reject;
    logic                done_take;
    logic                timeout_hit;
    logic                sel_ok;
    logic                rptr_ok;
    logic [31:0]         wr_lsb;
    logic [31:0]         rd_lsb;

    // Command qualification: while a job is in flight only NOP and ABORT are legal.
    assign abort_acc   = host_valid && (host_cmd == CMD_ABORT);
    assign idle_cmd    = host_valid && !busy;
    assign start_acc   = idle_cmd && (host_cmd == CMD_START);
    assign busy_reject = host_valid && busy && (host_cmd != CMD_NOP) && (host_cmd != CMD_ABORT);
    assign done_take   = (state_q == S_WAIT) && core_done && !abort_acc;
    assign sel_ok      = ({1'b0, host_data} < 9'(NUM_ARGS));
    assign rptr_ok     = ({1'b0, host_data} < 9'(RES_BYTES));
    assign wr_lsb      = 32'(sel_idx_q) * 32'(ARG_W) + 32'(wptr_q) * 32'd8;
    assign rd_lsb      = 32'(rptr_q) * 32'd8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_acc)  state_d = S_ISSUE;
            S_ISSUE: if (core_ready) state_d = S_WAIT;
            S_WAIT:  if (done_take)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit || abort_acc) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy       = 1'b0;
        core_start = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
                busy       = 1'b1;
                core_start = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q       <= '0;
            args_q         <= '0;
            result_q       <= '0;
            sel_idx_q      <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            if (idle_cmd) begin
                unique case (host_cmd)
                    CMD_NOP: ;
                    CMD_SET_OP: begin
                        opcode_q <= host_data[OP_W-1:0];
                        err_q    <= 1'b0;
                    end
                    CMD_SEL_ARG: begin
                        if (sel_ok) begin
                            sel_idx_q <= host_data[3:0];
                            wptr_q    <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    CMD_WR_BYTE: begin
                        args_q <= (args_q & ~(AW_TOT'(8'hFF) << wr_lsb))
                                | (AW_TOT'(host_data) << wr_lsb);
                        wptr_q <= (wptr_q == WPW'(ARG_BYTES - 1)) ? '0 : wptr_q + WPW'(1);
                    end
                    CMD_START: result_valid_q <= 1'b0;
                    CMD_RD_PTR: begin
                        if (rptr_ok) begin
                            rptr_q <= RPW'(host_data);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    CMD_RD_BYTE: rptr_q <= (rptr_q == RPW'(RES_BYTES - 1)) ? '0 : rptr_q + RPW'(1);
                    CMD_ABORT: ;
                endcase
            end
            if (busy_reject) begin
                err_q <= 1'b1;
            end
            if (abort_acc) begin
                err_q <= 1'b0;
            end
            if (done_take) begin
                result_q       <= core_result;
                result_valid_q <= 1'b1;
                rptr_q         <= '0;
            end
            if (timeout_hit) begin
                result_valid_q <= 1'b0;
            end
        end
    end

`ifdef HERALD_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;

    // Counter restarts on every accepted START and counts each busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_acc) begin
                tmo_cnt_q <= '0;
            end else if (busy) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
            if (start_acc) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_hit  = busy && !abort_acc && !done_take && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign timeout_flag = timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign rd_data     = 8'(result_q >> rd_lsb);
    assign status      = {sel_idx_q, timeout_flag, err_q, result_valid_q, busy};
    assign core_opcode = opcode_q;
    assign core_args   = args_q;

endmodule

// File: tb/tb_herald_cmd_bridge.sv
// Bench for herald_cmd_bridge: directed protocol sequence plus randomized traffic against a behavioural model.
module tb_herald_cmd_bridge;

    localparam int ARG_W    = 32;
    localparam int NUM_ARGS = 2;
    localparam int RES_W    = 64;
    localparam int OP_W     = 3;
    localparam int AB       = ARG_W / 8;
    localparam int RB       = RES_W / 8;
`ifdef HERALD_BRIDGE_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      host_valid = 1'b0;
    logic [2:0]                host_cmd = '0;
    logic [7:0]                host_data = '0;
    logic [7:0]                rd_data;
    logic [7:0]                status;
    logic [OP_W-1:0]           core_opcode;
    logic [NUM_ARGS*ARG_W-1:0] core_args;
    logic                      core_start;
    logic                      core_ready = 1'b0;
    logic                      core_done = 1'b0;
    logic [RES_W-1:0]          core_result = '0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    herald_cmd_bridge #(
        .ARG_W(ARG_W), .NUM_ARGS(NUM_ARGS), .RES_W(RES_W), .OP_W(OP_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_cmd(host_cmd),
        .host_data(host_data), .rd_data(rd_data), .status(status),
        .core_opcode(core_opcode), .core_args(core_args), .core_start(core_start),
        .core_ready(core_ready), .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    // Behavioural model: bytes in arrays, job tracked as "in flight" and "start granted".
    logic [OP_W-1:0]  m_op;
    logic [7:0]       m_arg [NUM_ARGS][AB];
    logic [RES_W-1:0] m_res;
    int               m_sel, m_wptr, m_rptr, m_cycles;
    bit               m_err, m_rv, m_tmo, m_busy, m_granted;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op = '0; m_res = '0; m_sel = 0; m_wptr = 0; m_rptr = 0; m_cycles = 0;
            m_err = 0; m_rv = 0; m_tmo = 0; m_busy = 0; m_granted = 0;
            for (int i = 0; i < NUM_ARGS; i++)
                for (int b = 0; b < AB; b++) m_arg[i][b] = '0;
        end else if (m_busy) begin
            if (host_valid && host_cmd == 3'd7) begin
                m_busy = 0;
                m_err = 0;
            end else begin
                if (host_valid && host_cmd != 3'd0) m_err = 1;
                if (!m_granted) begin
                    if (core_ready) m_granted = 1;
                end else if (core_done) begin
                    m_res = core_result; m_rv = 1; m_rptr = 0; m_busy = 0;
                end
`ifdef HERALD_BRIDGE_TIMEOUT_EN
                m_cycles++;
                if (m_busy && m_cycles == TMO) begin
                    m_busy = 0; m_tmo = 1; m_rv = 0;
                end
`endif
            end
        end else if (host_valid) begin
            case (host_cmd)
                3'd1: begin m_op = host_data[OP_W-1:0]; m_err = 0; end
                3'd2: if (host_data < NUM_ARGS) begin m_sel = host_data; m_wptr = 0; end
                      else m_err = 1;
                3'd3: begin m_arg[m_sel][m_wptr] = host_data; m_wptr = (m_wptr + 1) % AB; end
                3'd4: begin m_rv = 0; m_tmo = 0; m_busy = 1; m_granted = 0; m_cycles = 0; end
                3'd5: if (host_data < RB) m_rptr = host_data; else m_err = 1;
                3'd6: m_rptr = (m_rptr + 1) % RB;
                3'd7: m_err = 0;
                default: ;
            endcase
        end
    end

    function automatic logic [NUM_ARGS*ARG_W-1:0] exp_args();
        logic [NUM_ARGS*ARG_W-1:0] v = '0;
        for (int i = 0; i < NUM_ARGS; i++)
            for (int b = 0; b < AB; b++) v[i*ARG_W + b*8 +: 8] = m_arg[i][b];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("status", 64'(status), 64'({4'(m_sel), m_tmo, m_err, m_rv, m_busy}));
            check("rd_data", 64'(rd_data), 64'(8'(m_res >> (8 * m_rptr))));
            check("core_opcode", 64'(core_opcode), 64'(m_op));
            check("core_args", 64'(core_args), 64'(exp_args()));
            check("core_start", 64'(core_start), 64'(m_busy && !m_granted));
        end
    end

    task automatic send(input logic [2:0] c, input logic [7:0] d);
        host_valid = 1'b1; host_cmd = c; host_data = d;
        @(negedge clk);
        host_valid = 1'b0; host_cmd = '0; host_data = '0;
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_status", 64'(status), 64'h00);
        check("reset_rd", 64'(rd_data), 64'h00);
        check("reset_start", 64'(core_start), 64'h0);

        // Operand load
        send(3'd1, 8'h03);
        send(3'd2, 8'h00);
        send(3'd3, 8'h78); send(3'd3, 8'h56); send(3'd3, 8'h34); send(3'd3, 8'h12);
        send(3'd2, 8'h01);
        send(3'd3, 8'h04); send(3'd3, 8'h00); send(3'd3, 8'h00); send(3'd3, 8'h00);
        check("lit_opcode", 64'(core_opcode), 64'h3);
        check("lit_args", 64'(core_args), 64'h00000004_12345678);

        // Start handshake: ready low for 5 cycles, then high
        send(3'd4, 8'h00);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (core_start) cnt++;
            @(negedge clk);
        end
        core_ready = 1'b1;
        if (core_start) cnt++;
        @(negedge clk);
        core_ready = 1'b0;
        for (int i = 0; i < 20 && core_start; i++) begin
            cnt++;
            @(negedge clk);
        end
        check("start_len", 64'(cnt), 64'd6);
        repeat (9) @(negedge clk);
        core_result = 64'h1122334455667788;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("lit_done_status", 64'(status), 64'h12);
        for (int i = 0; i < 8; i++) begin
            check("lit_rd_byte", 64'(rd_data), 64'(8'h88 - 8'(8'h11 * i)));
            send(3'd6, 8'h00);
        end
        check("lit_rd_wrap", 64'(rd_data), 64'h88);

        // Error handling
        send(3'd2, 8'h05);
        check("lit_sel_err", 64'(status[2]), 64'h1);
        check("lit_sel_keep", 64'(status[7:4]), 64'h1);
        send(3'd1, 8'h02);
        check("lit_err_clr", 64'(status[2]), 64'h0);
        send(3'd4, 8'h00);
        send(3'd3, 8'hAA);
        check("lit_busy_err", 64'(status[2]), 64'h1);
        check("lit_busy_args", 64'(core_args), 64'h00000004_12345678);

        // Abort during WAIT, late done ignored
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        check("lit_wait_nostart", 64'(core_start), 64'h0);
        send(3'd7, 8'h00);
        check("lit_abort_status", 64'(status), 64'h10);
        core_result = 64'hDEADBEEF_CAFEF00D;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("lit_late_done", 64'(status), 64'h10);
        check("lit_result_kept", 64'(rd_data), 64'h88);

        // Asynchronous reset mid-ISSUE
        send(3'd4, 8'h00);
        check("lit_issue_start", 64'(core_start), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("lit_async_start", 64'(core_start), 64'h0);
        check("lit_async_status", 64'(status), 64'h00);
        @(negedge clk);
        rst_n = 1'b1;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("lit_post_rst_status", 64'(status), 64'h00);
        check("lit_post_rst_rd", 64'(rd_data), 64'h00);

`ifdef HERALD_BRIDGE_TIMEOUT_EN
        send(3'd4, 8'h00);
        core_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40 && status[0]; i++) begin
            cnt++;
            @(negedge clk);
        end
        core_ready = 1'b0;
        check("lit_tmo_len", 64'(cnt), 64'(TMO));
        check("lit_tmo_flag", 64'(status[3]), 64'h1);
        check("lit_tmo_busy", 64'(status[0]), 64'h0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            host_valid = ($urandom_range(0, 2) != 0);
            host_cmd   = 3'($urandom_range(0, 7));
            case (host_cmd)
                3'd2:    host_data = 8'($urandom_range(0, 3));
                3'd5:    host_data = 8'($urandom_range(0, 10));
                default: host_data = 8'($urandom_range(0, 255));
            endcase
            core_ready  = ($urandom_range(0, 2) == 0);
            core_done   = ($urandom_range(0, 5) == 0);
            core_result = {$urandom, $urandom};
            @(negedge clk);
        end
        host_valid = 1'b0;
        core_done = 1'b0;
        core_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
